mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares one AXI4 master port between the instruction cache (burst reads) and the load/store path (single-beat reads and writes), sitting between `ysyx_00000000_core` and the SoC bus. Arbitration is per-transaction and round-robin. It is non-preemptive, with at most one transaction outstanding. A beat counter checks that burst length matches `rlast`, and a mismatch raises a sticky error flag.

## Interface
Parameters:
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.

Ports (one clock; reset is synchronous and active-high):
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `icu_arvalid`/`icu_arready` in/out 1: icache AR handshake.
- `icu_araddr` in ADDR_W.
- `icu_arlen` in 8.
- `icu_arsize` in 3.
- `icu_arburst` in 2.
- `icu_rvalid`/`icu_rready` out/in 1: icache R handshake.
- `icu_rdata` out DATA_W.
- `icu_rresp` out 2.
- `icu_rlast` out 1.
- `lsu_arvalid`/`lsu_arready` in/out 1.
- `lsu_araddr` in ADDR_W.
- `lsu_arsize` in 3.
- `lsu_rvalid`/`lsu_rready` out/in 1.
- `lsu_rdata` out DATA_W.
- `lsu_rresp` out 2.
- `lsu_awvalid`/`lsu_awready` in/out 1.
- `lsu_awaddr` in ADDR_W.
- `lsu_wvalid`/`lsu_wready` in/out 1.
- `lsu_wdata` in DATA_W.
- `lsu_wstrb` in 4.
- `lsu_bvalid`/`lsu_bready` out/in 1.
- `lsu_bresp` out 2.
- `m_ar*` (`valid`, `ready`, `addr`, `len`, `size`, `burst`), `m_r*` (`valid`, `ready`, `data`, `resp`, `last`), `m_aw*` (`valid`, `ready`, `addr`, `len`, `size`, `burst`), `m_w*` (`valid`, `ready`, `data`, `strb`, `last`), `m_b*` (`valid`, `ready`, `resp`): AXI4 master, standard directions and widths.
- `burst_err` out 1: sticky; set when `rlast` disagrees with the latched `arlen`.

## Operation
- States:
  - `IDLE`: no grant.
  - `ICU_RD`: icache read granted.
  - `LSU_RD`: LSU read granted.
  - `LSU_WR`: LSU write granted.
- `last_lsu` register (reset 0): 1 if the most recent grant went to the LSU.
- In `IDLE`, the block samples `icu_arvalid`, `lsu_arvalid` and `lsu_awvalid`:
  - Only one requester pending: grant it.
  - Both requesters pending: grant icache if `last_lsu`=1, otherwise the LSU.
  - Within the LSU, read wins over write.
- In every granted state, the granted requester's channels pass combinationally to the master.
- All ungranted valids and readys are driven 0.
- Returns to `IDLE`:
  - `ICU_RD`: on an `m_r` handshake with `m_rlast`=1.
  - `LSU_RD`: on the first `m_r` handshake.
  - `LSU_WR`: on the `m_b` handshake.
- LSU reads drive `m_arlen`=0 and `m_arburst`=2'b01.
- LSU writes drive:
  - `m_awlen`=0, `m_awsize`=3'b010, `m_awburst`=2'b01, `m_wlast`=1.
- AW and W are forwarded independently, in either order. Each has its own done flag, cleared on entry to `LSU_WR`.
- A channel is masked after its handshake: once its done flag is set, its valid and ready are held 0 until the state exits.
- Beat counter, 8 bits:
  - Cleared and `arlen` latched at the `m_ar` handshake.
  - Incremented on each `m_r` handshake.
  - `burst_err` is set on an `m_r` handshake where `m_rlast` differs from (counter==latched `len`).
  - `burst_err` clears only on reset.
- `rresp` and `bresp` pass through unmodified; error responses do not alter sequencing.

## Timing
- Reset values:
  - State `IDLE`, `last_lsu`=0, counter 0, `burst_err`=0.
  - All `m_*valid`, `m_rready`, `m_bready` 0.
  - All requester readys and valids 0.
- Arbitration latency: a request seen in `IDLE` at cycle N is granted at N+1. `m_arvalid`/`m_awvalid` assert at N+1.
- The final handshake at cycle N makes the state `IDLE` at N+1. The earliest next grant is N+2.
- The master sees at most one outstanding transaction.
- Simultaneous `icu_arvalid` and `lsu_arvalid` with `last_lsu`=0: LSU granted. The following contended arbitration goes to the icache.
- Requests arriving during a grant wait; a requester must hold valid high until its grant.
- Reset mid-transaction: return to `IDLE` next cycle, all valids drop. The bus and requesters are reset in the same cycle.

## Test plan
- **Single icache burst:** `icu_araddr`=0x3000_0000, `arlen`=3, INCR → one `m_ar` with `len`=3. Four beats forwarded to `icu_r*`, `rlast` on beat 4, `IDLE` the next cycle, `burst_err`=0.
- **Contention:**
  - Stimulus: `icu_arvalid` and `lsu_arvalid` asserted in the same cycle from reset.
  - First: the LSU read at 0x8000_0010 is issued first (`m_arlen`=0).
  - Then: the icache read is issued at the earliest slot, 2 cycles after the LSU `m_r` handshake.
- **LSU store, W before AW:** `lsu_wvalid` in the grant cycle, `m_awready` delayed 3 cycles, `wstrb`=4'b0011 → `m_wstrb`=0011 and `m_wlast`=1. Exactly one W handshake, `lsu_bresp` = `m_bresp`.
- **Round-robin fairness:** icache and LSU both re-request continuously for 6 transactions → grants alternate LSU, icu, LSU, icu, LSU, icu.
- **Burst mismatch:** `arlen`=3 with the slave asserting `m_rlast` on beat 2 → `burst_err`=1 from the next cycle, state returns to `IDLE`, and `burst_err` stays 1 until reset.
- **Reset mid-burst:** `reset` asserted after beat 1 of a 4-beat burst → next cycle all valids 0 and state `IDLE`. After reset release, a new LSU read is granted in 1 cycle.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shares one AXI4 master between the icache (burst reads) and the LSU (single-beat reads/writes).
// Round-robin per transaction, non-preemptive, one transaction outstanding, burst-length checker.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  // icache read port
  input  logic              icu_arvalid,
  output logic              icu_arready,
  input  logic [ADDR_W-1:0] icu_araddr,
  input  logic [7:0]        icu_arlen,
  input  logic [2:0]        icu_arsize,
  input  logic [1:0]        icu_arburst,
  output logic              icu_rvalid,
  input  logic              icu_rready,
  output logic [DATA_W-1:0] icu_rdata,
  output logic [1:0]        icu_rresp,
  output logic              icu_rlast,
  // load/store port
  input  logic              lsu_arvalid,
  output logic              lsu_arready,
  input  logic [ADDR_W-1:0] lsu_araddr,
  input  logic [2:0]        lsu_arsize,
  output logic              lsu_rvalid,
  input  logic              lsu_rready,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic [1:0]        lsu_rresp,
  input  logic              lsu_awvalid,
  output logic              lsu_awready,
  input  logic [ADDR_W-1:0] lsu_awaddr,
  input  logic              lsu_wvalid,
  output logic              lsu_wready,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [3:0]        lsu_wstrb,
  output logic              lsu_bvalid,
  input  logic              lsu_bready,
  output logic [1:0]        lsu_bresp,
  // AXI4 master
  output logic              m_arvalid,
  input  logic              m_arready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [7:0]        m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  input  logic              m_rvalid,
  output logic              m_rready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [ADDR_W-1:0] m_awaddr,
  output logic [7:0]        m_awlen,
  output logic [2:0]        m_awsize,
  output logic [1:0]        m_awburst,
  output logic              m_wvalid,
  input  logic              m_wready,
  output logic [DATA_W-1:0] m_wdata,
  output logic [3:0]        m_wstrb,
  output logic              m_wlast,
  input  logic              m_bvalid,
  output logic              m_bready,
  input  logic [1:0]        m_bresp,
  output logic              burst_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ICU_RD = 2'd1,
    LSU_RD = 2'd2,
    LSU_WR = 2'd3
  } state_t;

  state_t     r_state;
  logic       r_last_lsu;
  logic       r_ar_done;
  logic       r_aw_done;
  logic       r_w_done;
  logic [7:0] r_beat;
  logic [7:0] r_len;
  logic       r_burst_err;

  logic w_ar_hs;
  logic w_r_hs;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_b_hs;
  logic w_lsu_req;

  assign w_ar_hs   = m_arvalid & m_arready;
  assign w_r_hs    = m_rvalid & m_rready;
  assign w_aw_hs   = m_awvalid & m_awready;
  assign w_w_hs    = m_wvalid & m_wready;
  assign w_b_hs    = m_bvalid & m_bready;
  assign w_lsu_req = lsu_arvalid | lsu_awvalid;

  // Write side is fixed single-beat word-aligned; payloads and responses flow straight through.
  assign m_awaddr  = lsu_awaddr;
  assign m_awlen   = 8'd0;
  assign m_awsize  = 3'b010;
  assign m_awburst = 2'b01;
  assign m_wdata   = lsu_wdata;
  assign m_wstrb   = lsu_wstrb;
  assign m_wlast   = 1'b1;
  assign icu_rdata = m_rdata;
  assign icu_rresp = m_rresp;
  assign icu_rlast = m_rlast;
  assign lsu_rdata = m_rdata;
  assign lsu_rresp = m_rresp;
  assign lsu_bresp = m_bresp;
  assign burst_err = r_burst_err;

  // Grant FSM with per-channel done flags that mask a channel once it has handshaken.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_last_lsu <= 1'b0;
      r_ar_done  <= 1'b0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_ar_done <= 1'b0;
          r_aw_done <= 1'b0;
          r_w_done  <= 1'b0;
          if (icu_arvalid && (!w_lsu_req || r_last_lsu)) begin
            r_state    <= ICU_RD;
            r_last_lsu <= 1'b0;
          end else if (lsu_arvalid) begin
            r_state    <= LSU_RD;
            r_last_lsu <= 1'b1;
          end else if (lsu_awvalid) begin
            r_state    <= LSU_WR;
            r_last_lsu <= 1'b1;
          end else begin
            r_state <= IDLE;
          end
        end
        ICU_RD: begin
          if (w_ar_hs) r_ar_done <= 1'b1;
          if (w_r_hs && m_rlast) r_state <= IDLE;
        end
        LSU_RD: begin
          if (w_ar_hs) r_ar_done <= 1'b1;
          if (w_r_hs) r_state <= IDLE;
        end
        LSU_WR: begin
          if (w_aw_hs) r_aw_done <= 1'b1;
          if (w_w_hs) r_w_done <= 1'b1;
          if (w_b_hs) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Beat counter: rlast must coincide with the beat numbered arlen.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_beat      <= 8'd0;
      r_len       <= 8'd0;
      r_burst_err <= 1'b0;
    end else if (w_ar_hs) begin
      r_beat <= 8'd0;
      r_len  <= m_arlen;
    end else if (w_r_hs) begin
      r_beat <= r_beat + 8'd1;
      if (m_rlast != (r_beat == r_len)) r_burst_err <= 1'b1;
    end
  end

  // Route the granted requester's handshakes; everything ungranted reads as 0.
  always_comb begin
    m_arvalid   = 1'b0;
    m_araddr    = lsu_araddr;
    m_arlen     = 8'd0;
    m_arsize    = lsu_arsize;
    m_arburst   = 2'b01;
    m_rready    = 1'b0;
    m_awvalid   = 1'b0;
    m_wvalid    = 1'b0;
    m_bready    = 1'b0;
    icu_arready = 1'b0;
    icu_rvalid  = 1'b0;
    lsu_arready = 1'b0;
    lsu_rvalid  = 1'b0;
    lsu_awready = 1'b0;
    lsu_wready  = 1'b0;
    lsu_bvalid  = 1'b0;
    case (r_state)
      ICU_RD: begin
        m_arvalid   = icu_arvalid & ~r_ar_done;
        icu_arready = m_arready & ~r_ar_done;
        m_araddr    = icu_araddr;
        m_arlen     = icu_arlen;
        m_arsize    = icu_arsize;
        m_arburst   = icu_arburst;
        m_rready    = icu_rready & r_ar_done;
        icu_rvalid  = m_rvalid & r_ar_done;
      end
      LSU_RD: begin
        m_arvalid   = lsu_arvalid & ~r_ar_done;
        lsu_arready = m_arready & ~r_ar_done;
        m_rready    = lsu_rready & r_ar_done;
        lsu_rvalid  = m_rvalid & r_ar_done;
      end
      LSU_WR: begin
        m_awvalid   = lsu_awvalid & ~r_aw_done;
        lsu_awready = m_awready & ~r_aw_done;
        m_wvalid    = lsu_wvalid & ~r_w_done;
        lsu_wready  = m_wready & ~r_w_done;
        m_bready    = lsu_bready;
        lsu_bvalid  = m_bvalid;
      end
      default: begin
        m_arvalid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: AR and R expectations are queued at stimulus time and popped at the DUT output.
module tb_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clock = 1'b0;
  logic              reset;
  logic              icu_arvalid, icu_arready, icu_rvalid, icu_rready, icu_rlast;
  logic [ADDR_W-1:0] icu_araddr;
  logic [7:0]        icu_arlen;
  logic [2:0]        icu_arsize;
  logic [1:0]        icu_arburst, icu_rresp;
  logic [DATA_W-1:0] icu_rdata;
  logic              lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
  logic [ADDR_W-1:0] lsu_araddr, lsu_awaddr;
  logic [2:0]        lsu_arsize;
  logic [DATA_W-1:0] lsu_rdata, lsu_wdata;
  logic [1:0]        lsu_rresp, lsu_bresp;
  logic              lsu_awvalid, lsu_awready, lsu_wvalid, lsu_wready, lsu_bvalid, lsu_bready;
  logic [3:0]        lsu_wstrb;
  logic              m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
  logic [ADDR_W-1:0] m_araddr, m_awaddr;
  logic [7:0]        m_arlen, m_awlen;
  logic [2:0]        m_arsize, m_awsize;
  logic [1:0]        m_arburst, m_awburst, m_rresp, m_bresp;
  logic [DATA_W-1:0] m_rdata, m_wdata;
  logic              m_awvalid, m_awready, m_wvalid, m_wready, m_wlast, m_bvalid, m_bready;
  logic [3:0]        m_wstrb;
  logic              burst_err;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock(clock), .reset(reset),
    .icu_arvalid(icu_arvalid), .icu_arready(icu_arready), .icu_araddr(icu_araddr),
    .icu_arlen(icu_arlen), .icu_arsize(icu_arsize), .icu_arburst(icu_arburst),
    .icu_rvalid(icu_rvalid), .icu_rready(icu_rready), .icu_rdata(icu_rdata),
    .icu_rresp(icu_rresp), .icu_rlast(icu_rlast),
    .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready), .lsu_araddr(lsu_araddr),
    .lsu_arsize(lsu_arsize), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
    .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp),
    .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready), .lsu_awaddr(lsu_awaddr),
    .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready), .lsu_wdata(lsu_wdata),
    .lsu_wstrb(lsu_wstrb), .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
    .lsu_bresp(lsu_bresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rlast(m_rlast),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
    .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_wlast(m_wlast),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .burst_err(burst_err)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [1:0]  burst;
  } ar_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_t;

  ar_t ar_q[$];
  r_t  r_q[$];
  int  checks = 0;
  int  errors = 0;
  int  w_hs   = 0;

  always @(posedge clock) begin
    if (m_wvalid && m_wready) w_hs++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Wait (bounded) for m_arvalid, then compare the request against the queued expectation.
  task automatic wait_ar(input string tag, output int n);
    ar_t e;
    n = 0;
    #1;
    while (m_arvalid !== 1'b1 && n < 20) begin
      @(posedge clock);
      #2;
      n++;
    end
    chk({tag, "_seen"}, 64'(m_arvalid), 64'(1'b1));
    if (ar_q.size() > 0) e = ar_q.pop_front();
    else e = {32'hDEAD_BEEF, 8'hFF, 2'b11};
    chk({tag, "_addr"}, 64'(m_araddr), 64'(e.addr));
    chk({tag, "_len"}, 64'(m_arlen), 64'(e.len));
    chk({tag, "_burst"}, 64'(m_arburst), 64'(e.burst));
  endtask

  // Slave-side R beats; the expected requester-side beat is queued as each one is driven.
  task automatic serve_r(input string tag, input bit to_icu, input int beats,
                         input int last_idx, input logic [31:0] base);
    r_t e;
    for (int b = 0; b < beats; b++) begin
      m_rvalid = 1'b1;
      m_rdata  = base + 32'(b);
      m_rresp  = 2'(b);
      m_rlast  = (b == last_idx);
      e = {m_rdata, m_rresp, m_rlast};
      r_q.push_back(e);
      #1;
      e = r_q.pop_front();
      chk({tag, "_rready"}, 64'(m_rready), 64'(1'b1));
      if (to_icu) begin
        chk({tag, "_icu_rvalid"}, 64'(icu_rvalid), 64'(1'b1));
        chk({tag, "_lsu_rvalid"}, 64'(lsu_rvalid), 64'(1'b0));
        chk({tag, "_icu_rdata"}, 64'(icu_rdata), 64'(e.data));
        chk({tag, "_icu_rresp"}, 64'(icu_rresp), 64'(e.resp));
        chk({tag, "_icu_rlast"}, 64'(icu_rlast), 64'(e.last));
      end else begin
        chk({tag, "_lsu_rvalid"}, 64'(lsu_rvalid), 64'(1'b1));
        chk({tag, "_icu_rvalid"}, 64'(icu_rvalid), 64'(1'b0));
        chk({tag, "_lsu_rdata"}, 64'(lsu_rdata), 64'(e.data));
        chk({tag, "_lsu_rresp"}, 64'(lsu_rresp), 64'(e.resp));
      end
      cyc();
    end
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
  endtask

  initial begin
    int  n;
    int  w0;
    ar_t a;
    reset = 1'b1;
    icu_arvalid = 1'b0; icu_araddr = 32'h0; icu_arlen = 8'd0; icu_arsize = 3'b010;
    icu_arburst = 2'b01; icu_rready = 1'b1;
    lsu_arvalid = 1'b0; lsu_araddr = 32'h0; lsu_arsize = 3'b010; lsu_rready = 1'b1;
    lsu_awvalid = 1'b0; lsu_awaddr = 32'h0; lsu_wvalid = 1'b0; lsu_wdata = 32'h0;
    lsu_wstrb = 4'b0000; lsu_bready = 1'b1;
    m_arready = 1'b1; m_rvalid = 1'b0; m_rdata = 32'h0; m_rresp = 2'b00; m_rlast = 1'b0;
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = 2'b00;

    // Reset state
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    #1;
    chk("rst_master", 64'({m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready}), 64'(5'b0));
    chk("rst_reqs", 64'({icu_arready, icu_rvalid, lsu_arready, lsu_rvalid,
                          lsu_awready, lsu_wready, lsu_bvalid}), 64'(7'b0));
    chk("rst_err", 64'(burst_err), 64'(1'b0));

    // Contention from reset: LSU first, icache at the earliest following slot
    icu_arvalid = 1'b1; icu_araddr = 32'h3000_0000; icu_arlen = 8'd1;
    lsu_arvalid = 1'b1; lsu_araddr = 32'h8000_0010;
    a = {32'h8000_0010, 8'd0, 2'b01}; ar_q.push_back(a);
    a = {32'h3000_0000, 8'd1, 2'b01}; ar_q.push_back(a);
    wait_ar("cont_lsu", n);
    chk("cont_lsu_lat", 64'(n), 64'(1));
    chk("cont_icu_blocked", 64'(icu_arready), 64'(1'b0));
    cyc();
    lsu_arvalid = 1'b0;
    serve_r("cont_lsu_r", 1'b0, 1, 0, 32'h1111_0000);
    wait_ar("cont_icu", n);
    chk("cont_icu_lat", 64'(n), 64'(1));
    cyc();
    icu_arvalid = 1'b0;
    serve_r("cont_icu_r", 1'b1, 2, 1, 32'h2222_0000);

    // Single 4-beat icache burst
    icu_arvalid = 1'b1; icu_araddr = 32'h3000_0000; icu_arlen = 8'd3;
    a = {32'h3000_0000, 8'd3, 2'b01}; ar_q.push_back(a);
    wait_ar("burst", n);
    chk("burst_lat", 64'(n), 64'(1));
    cyc();
    icu_arvalid = 1'b0;
    serve_r("burst_r", 1'b1, 4, 3, 32'hA000_0000);
    #1;
    chk("burst_idle", 64'({m_arvalid, m_rready, icu_rvalid}), 64'(3'b0));
    chk("burst_err0", 64'(burst_err), 64'(1'b0));

    // Round-robin with both requesters held high
    icu_arvalid = 1'b1; icu_araddr = 32'h3000_0400; icu_arlen = 8'd1;
    lsu_arvalid = 1'b1; lsu_araddr = 32'h8000_0020;
    for (int t = 0; t < 6; t++) begin
      if (t % 2 == 0) a = {32'h8000_0020, 8'd0, 2'b01};
      else            a = {32'h3000_0400, 8'd1, 2'b01};
      ar_q.push_back(a);
    end
    for (int t = 0; t < 6; t++) begin
      wait_ar($sformatf("rr%0d", t), n);
      chk($sformatf("rr%0d_lat", t), 64'(n), 64'(1));
      chk($sformatf("rr%0d_icu_ardy", t), 64'(icu_arready), 64'(t % 2 == 1));
      chk($sformatf("rr%0d_lsu_ardy", t), 64'(lsu_arready), 64'(t % 2 == 0));
      cyc();
      if (t % 2 == 0) serve_r($sformatf("rr%0d_r", t), 1'b0, 1, 0, 32'h5000_0000 + 32'(t));
      else            serve_r($sformatf("rr%0d_r", t), 1'b1, 2, 1, 32'h6000_0000 + 32'(t));
    end
    icu_arvalid = 1'b0;
    lsu_arvalid = 1'b0;

    // LSU store, W ahead of AW, AW accepted after 3 cycles
    w0 = w_hs;
    m_awready = 1'b0; m_wready = 1'b1;
    lsu_awvalid = 1'b1; lsu_awaddr = 32'h8000_0100;
    lsu_wdata = 32'hCAFE_F00D; lsu_wstrb = 4'b0011;
    #1;
    chk("st_idle_aw", 64'(m_awvalid), 64'(1'b0));
    cyc();
    lsu_wvalid = 1'b1;
    #1;
    chk("st_aw_fields", 64'({m_awvalid, m_awaddr, m_awlen, m_awsize, m_awburst}),
        64'({1'b1, 32'h8000_0100, 8'd0, 3'b010, 2'b01}));
    chk("st_w_fields", 64'({m_wvalid, lsu_wready, m_wdata, m_wstrb, m_wlast}),
        64'({1'b1, 1'b1, 32'hCAFE_F00D, 4'b0011, 1'b1}));
    cyc();
    #1;
    chk("st_w_masked", 64'({m_wvalid, lsu_wready, m_awvalid}), 64'({1'b0, 1'b0, 1'b1}));
    cyc();
    m_awready = 1'b1;
    #1;
    chk("st_awready", 64'(lsu_awready), 64'(1'b1));
    cyc();
    lsu_awvalid = 1'b0; lsu_wvalid = 1'b0; m_awready = 1'b0;
    m_bvalid = 1'b1; m_bresp = 2'b10;
    #1;
    chk("st_aw_done", 64'({m_awvalid, m_wvalid}), 64'(2'b00));
    chk("st_b", 64'({lsu_bvalid, m_bready, lsu_bresp}), 64'({1'b1, 1'b1, 2'b10}));
    cyc();
    m_bvalid = 1'b0;
    #1;
    chk("st_one_w", 64'(w_hs - w0), 64'(1));
    chk("st_idle", 64'({m_bready, lsu_bvalid}), 64'(2'b00));

    // Burst mismatch: arlen 3, rlast on beat 2
    icu_arvalid = 1'b1; icu_araddr = 32'h3000_0100; icu_arlen = 8'd3;
    a = {32'h3000_0100, 8'd3, 2'b01}; ar_q.push_back(a);
    wait_ar("mm", n);
    cyc();
    icu_arvalid = 1'b0;
    serve_r("mm_r", 1'b1, 2, 1, 32'hB000_0000);
    #1;
    chk("mm_err", 64'(burst_err), 64'(1'b1));
    chk("mm_idle", 64'(m_rready), 64'(1'b0));
    lsu_arvalid = 1'b1; lsu_araddr = 32'h8000_0030;
    a = {32'h8000_0030, 8'd0, 2'b01}; ar_q.push_back(a);
    wait_ar("mm_next", n);
    chk("mm_next_lat", 64'(n), 64'(1));
    cyc();
    lsu_arvalid = 1'b0;
    serve_r("mm_next_r", 1'b0, 1, 0, 32'hB100_0000);
    #1;
    chk("mm_err_sticky", 64'(burst_err), 64'(1'b1));

    // Reset after the first beat of a 4-beat burst
    icu_arvalid = 1'b1; icu_araddr = 32'h3000_0200; icu_arlen = 8'd3;
    a = {32'h3000_0200, 8'd3, 2'b01}; ar_q.push_back(a);
    wait_ar("rb", n);
    cyc();
    icu_arvalid = 1'b0;
    m_rvalid = 1'b1; m_rdata = 32'hC000_0000; m_rlast = 1'b0;
    #1;
    chk("rb_beat1", 64'(icu_rvalid), 64'(1'b1));
    cyc();
    reset = 1'b1; m_rvalid = 1'b0;
    cyc();
    reset = 1'b0;
    #1;
    chk("rb_valids", 64'({m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready,
                           icu_rvalid, lsu_rvalid, lsu_bvalid}), 64'(8'b0));
    chk("rb_err_clr", 64'(burst_err), 64'(1'b0));
    lsu_arvalid = 1'b1; lsu_araddr = 32'h8000_0040;
    a = {32'h8000_0040, 8'd0, 2'b01}; ar_q.push_back(a);
    wait_ar("rb_lsu", n);
    chk("rb_lsu_lat", 64'(n), 64'(1));
    cyc();
    lsu_arvalid = 1'b0;
    serve_r("rb_lsu_r", 1'b0, 1, 0, 32'hD000_0000);

    chk("ar_q_empty", 64'(ar_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
